// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the responder FSM state encoding, the word width and the byte-lane count.
// Imported by dmem_responder and dmem_array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH_WORDS x WORD_W, synchronous byte-enabled write, combinational read.
// Latency: a write lands on the clock edge; the read port follows addr within the same cycle.
// Backpressure: none; contents are never reset.
// Ports: clk; we/be/wdata write controls; addr shared word index; rdata read word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states and range/alignment errors.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept cycle; a store commits on that edge.
// Backpressure: the response is held until rsp_ready; one IDLE turnaround cycle follows before req_ready.
// Ports: clk, reset (sync, active-low); req_valid/req_ready/req_we/req_addr/req_wdata/req_be request;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response.
// Build option: define DMEM_ALIGN_CHECK_EN to flag addr[1:0] != 0 as an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              retire_q;

    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [LANES-1:0]  lat_be;

    logic              accept;
    logic              enter_resp;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [LANES-1:0]  cur_be;
    logic              range_err;
    logic              cur_err;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // retire_q marks the IDLE cycle right after a response retires; no accept is allowed there.
    assign req_ready = reset && (state == IDLE) && !retire_q;
    assign accept    = req_valid && req_ready;

    // With zero wait states RESP is entered on the accept edge itself, before the latch
    // registers hold the request, so the live request feeds the commit path in IDLE.
    assign cur_we    = (state == IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == IDLE) ? req_be    : lat_be;

    assign range_err = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
    assign cur_err = range_err || (cur_addr[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^cur_addr[1:0];
    assign cur_err    = range_err;
`endif

    assign enter_resp = (state == IDLE) ? (accept && (WAIT_CYCLES == 0))
                                        : ((state == WAIT) && (wait_cnt == 4'd0));

    // reset gates the write so a store aborted in WAIT never reaches storage.
    assign mem_we = reset && enter_resp && cur_we && !cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (cur_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            retire_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        retire_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_we || cur_err) ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states, one with none.
// Expected responses come from a word-array memory model updated at issue time.
// Honours DMEM_ALIGN_CHECK_EN the same way the design does.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WC    = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          stall;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;
    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_be0;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          next_stall = 0;
    bit          in_rsp = 1'b0;
    int          stall_left = 0;
    exp_t        cur_e;
    exp_t        e0;
    exp_t        exp_q[$];
    exp_t        q0[$];
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference memory: word index = addr/4; out-of-range or (optionally) misaligned is an error.
    function automatic exp_t model_apply(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   w;
        w       = int'(addr >> 2);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.acc   = 0;
        e.stall = 0;
        if (w >= DEPTH || (ALIGN && (addr % 4) != 0)) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model_mem[w][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            e.rdata = model_mem[w];
        end
        return e;
    endfunction

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit track);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: req_ready=0 for %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            e       = model_apply(we, addr, wdata, be);
            e.acc   = cyc;
            e.stall = next_stall;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || in_rsp) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || q0.size() != 0 || in_rsp) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size() + q0.size());
            exp_q.delete();
            q0.delete();
        end
    endtask

    // Response monitor for the 2-wait-state instance; also owns rsp_ready (stall per response).
    always @(negedge clk) begin
        if (!reset) begin
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
        end else if (in_rsp && rsp_ready) begin
            chk1("rsp_drop_after_handshake", rsp_valid, 1'b0);
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL orphan_rsp: rsp_valid=1 with no request outstanding");
                    rsp_ready = 1'b1;
                end else begin
                    cur_e      = exp_q.pop_front();
                    in_rsp     = 1'b1;
                    stall_left = cur_e.stall;
                    chk("rsp_latency", 32'(cyc - cur_e.acc), 32'(WC + 1));
                    chk("rsp_rdata", rsp_rdata, cur_e.rdata);
                    chk1("rsp_err", rsp_err, cur_e.err);
                    chk1("resp_req_ready", req_ready, 1'b0);
                end
            end else begin
                chk("hold_rdata", rsp_rdata, cur_e.rdata);
                chk1("hold_err", rsp_err, cur_e.err);
                chk1("hold_req_ready", req_ready, 1'b0);
            end
            if (in_rsp) begin
                if (stall_left == 0) begin
                    rsp_ready = 1'b1;
                end else begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end
            end
        end else begin
            rsp_ready = 1'b0;
        end
    end

    // Response monitor for the zero-wait-state instance (rsp_ready tied high).
    always @(negedge clk) begin
        if (reset && rsp_valid0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b2b_orphan: rsp_valid=1 with no request outstanding");
            end else begin
                e0 = q0.pop_front();
                chk("b2b_latency", 32'(cyc - e0.acc), 32'd1);
                chk("b2b_rdata", rsp_rdata0, e0.rdata);
                chk1("b2b_err", rsp_err0, e0.err);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        int          r;
        int          n;
        int          accepts;
        int          last;
        exp_t        e;

        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
        rsp_ready0 = 1'b1;

        repeat (3) @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rel_req_ready", req_ready, 1'b1);

        for (int w = 0; w < 16; w++) send(1'b1, 32'(w * 4), $urandom(), 4'hF, 1'b1);

        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);

        next_stall = 5;
        send(1'b0, 32'h10, 32'h0, 4'h3, 1'b1);
        next_stall = 0;

        send(1'b0, 32'h400, 32'h0, 4'hF, 1'b1);
        send(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1);
        send(1'b0, 32'h11, 32'h0, 4'hF, 1'b1);
        send(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 1'b1);
        send(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        send(1'b1, 32'h14, 32'h55555555, 4'h0, 1'b1);
        send(1'b0, 32'h14, 32'h0, 4'hF, 1'b1);
        drain();

        // Store aborted by reset while waiting: contents of word 0x20 must survive.
        send(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("abort_rsp_valid", rsp_valid, 1'b0);
        chk1("abort_req_ready", req_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("abort_rel_req_ready", req_ready, 1'b1);
        chk1("abort_rel_rsp_valid", rsp_valid, 1'b0);
        send(1'b0, 32'h20, 32'h0, 4'hF, 1'b1);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            else        a = (32'($urandom_range(0, 15)) << 2) | ((r == 1) ? 32'($urandom_range(1, 3)) : 32'h0);
            next_stall = $urandom_range(0, 2);
            send(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 1'b1);
        end
        next_stall = 0;
        drain();

        // Zero-wait-state instance: one store, then back-to-back loads of the same word.
        v = $urandom();
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h14; req_wdata0 = v; req_be0 = 4'hF;
        n = 0;
        while (!req_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("b2b_store_ready", req_ready0, 1'b1);
        e.rdata = 32'h0; e.err = 1'b0; e.acc = cyc; e.stall = 0;
        q0.push_back(e);
        @(posedge clk);
        #1 req_valid0 = 1'b0;

        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h14; req_be0 = 4'h0;
        accepts = 0;
        last = -1;
        n = 0;
        while (accepts < 4 && n < 60) begin
            if (req_ready0) begin
                e.rdata = v; e.err = 1'b0; e.acc = cyc; e.stall = 0;
                q0.push_back(e);
                if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                accepts++;
            end
            @(negedge clk);
            n++;
        end
        req_valid0 = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd4);
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
